cpu_bus_fabric: RTL and testbench

- Parametrised chip-select decoder, acknowledge multiplexer and bus watchdog between the SCC68070 core bus and N peripheral regions (MCD212, CDIC, slave uC, NVRAM, ...).
- Generalises the fixed per-device decode/ack mux of the CD-i top level.
- Adds per-region base/mask decode, programmable fixed wait states or external ack, registered read data, unmapped-address and timeout bus errors, and error capture.

---
 rtl/bus_fabric_pkg.sv | 13 +
 rtl/bus_region_decoder.sv | 25 ++
 rtl/cpu_bus_fabric.sv | 154 +++++++++++++++
 tb/tb_cpu_bus_fabric.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: shared state encoding, wait-code constant and region match helper for the CPU bus fabric.
package bus_fabric_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, ACK, ERR} state_e;

   localparam logic [3:0] WAIT_EXTERNAL = 4'hF;

   function automatic logic region_hit(input logic [23:0] addr, input logic [23:0] base,
                                       input logic [23:0] mask);
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: combinational base/mask decode of N regions; lowest matching index wins.
module bus_region_decoder
   import bus_fabric_pkg::*;
#(
   parameter int                        NUM_REGIONS = 4,
   parameter int                        IW          = 2,
   parameter logic [24*NUM_REGIONS-1:0] REGION_BASE = '0,
   parameter logic [24*NUM_REGIONS-1:0] REGION_MASK = '0
) (
   input  logic [23:0]   addr_i,
   output logic          hit_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--)
         if (region_hit(addr_i, REGION_BASE[24*i +: 24], REGION_MASK[24*i +: 24])) begin
            hit_o = 1'b1;
            idx_o = IW'(i);
         end
   end

endmodule

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: SCC68070 chip-select decode, ack multiplexer and bus watchdog with error capture.
module cpu_bus_fabric
   import bus_fabric_pkg::*;
#(
   parameter int                        NUM_REGIONS = 4,
   parameter logic [24*NUM_REGIONS-1:0] REGION_BASE = '0,
   parameter logic [24*NUM_REGIONS-1:0] REGION_MASK = '0,
   parameter logic [4*NUM_REGIONS-1:0]  REGION_WAIT = {NUM_REGIONS{4'hF}},
   parameter int                        TIMEOUT     = 255
) (
   input  logic                      clk30,
   input  logic                      reset,
   input  logic                      cpu_as,
   input  logic                      cpu_uds,
   input  logic                      cpu_lds,
   input  logic                      cpu_write_strobe,
   input  logic [23:1]               cpu_addr,
   output logic [15:0]               cpu_data_in,
   output logic                      cpu_bus_ack,
   output logic                      cpu_bus_err,
   output logic [NUM_REGIONS-1:0]    slv_cs,
   input  logic [16*NUM_REGIONS-1:0] slv_dout,
   input  logic [NUM_REGIONS-1:0]    slv_ack,
   output logic [23:0]               err_addr,
   output logic                      err_is_timeout,
   output logic [7:0]                err_count
);

   localparam int IW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d, dec_idx;
   logic          hit_q, hit_d, dec_hit;
   logic          ext_q, ext_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [9:0]    tcnt_q, tcnt_d;
   logic [23:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          ack_q, err_q;
   logic [23:0]   err_addr_q, err_addr_d;
   logic          err_to_q, err_to_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic [23:0]   addr_byte;
   logic [3:0]    reg_wait;
   logic [9:0]    tcnt_inc;
   logic          got_ack, tmo;
   logic          unused_write;

   assign unused_write = cpu_write_strobe;
   assign addr_byte    = {cpu_addr, 1'b0};
   assign reg_wait     = REGION_WAIT[dec_idx*4 +: 4];
   assign tcnt_inc     = tcnt_q + 10'd1;
   assign tmo          = tcnt_inc == 10'(TIMEOUT);
   assign got_ack      = hit_q && (ext_q ? slv_ack[idx_q] : wcnt_q == 4'd0);

   bus_region_decoder #(
      .NUM_REGIONS(NUM_REGIONS),
      .IW         (IW),
      .REGION_BASE(REGION_BASE),
      .REGION_MASK(REGION_MASK)
   ) u_dec (
      .addr_i(addr_byte),
      .hit_o (dec_hit),
      .idx_o (dec_idx)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hit_d      = hit_q;
      ext_d      = ext_q;
      wcnt_d     = wcnt_q;
      tcnt_d     = tcnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      err_addr_d = err_addr_q;
      err_to_d   = err_to_q;
      err_cnt_d  = err_cnt_q;
      case (state_q)
         IDLE:
            if (cpu_as && (cpu_uds || cpu_lds)) begin
               state_d = ACTIVE;
               idx_d   = dec_idx;
               hit_d   = dec_hit;
               ext_d   = reg_wait == WAIT_EXTERNAL;
               wcnt_d  = reg_wait;
               tcnt_d  = '0;
               addr_d  = addr_byte;
            end
         ACTIVE:
            // abort beats ack, ack beats timeout; unmapped cycles have no ack source
            if (!cpu_as) begin
               state_d = IDLE;
            end else if (got_ack) begin
               state_d = ACK;
               data_d  = slv_dout[idx_q*16 +: 16];
            end else if (!hit_q || tmo) begin
               state_d    = ERR;
               err_addr_d = addr_q;
               err_to_d   = hit_q;
               err_cnt_d  = err_cnt_q + 8'(err_cnt_q != 8'hFF);
            end else begin
               wcnt_d = wcnt_q - 4'd1;
               tcnt_d = tcnt_inc;
            end
         ACK, ERR:
            state_d = cpu_as ? state_q : IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk30) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         hit_q      <= 1'b0;
         ext_q      <= 1'b0;
         wcnt_q     <= '0;
         tcnt_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
         err_to_q   <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hit_q      <= hit_d;
         ext_q      <= ext_d;
         wcnt_q     <= wcnt_d;
         tcnt_q     <= tcnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         ack_q      <= state_d == ACK;
         err_q      <= state_d == ERR;
         err_addr_q <= err_addr_d;
         err_to_q   <= err_to_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // selects drop outside ACTIVE so toggle-style slaves see a clean deselect
   assign slv_cs         = (state_q == ACTIVE && hit_q) ? NUM_REGIONS'(1) << idx_q : '0;
   assign cpu_data_in    = data_q;
   assign cpu_bus_ack    = ack_q;
   assign cpu_bus_err    = err_q;
   assign err_addr       = err_addr_q;
   assign err_is_timeout = err_to_q;
   assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb_cpu_bus_fabric: directed transactions checked every cycle against a transaction-level model.
module tb_cpu_bus_fabric;

   localparam int          N       = 4;
   localparam int          TMO     = 255;
   localparam logic [23:0] BASE_A [4] = '{24'h000000, 24'h300000, 24'h000000, 24'h800000};
   localparam logic [23:0] MASK_A [4] = '{24'hF00000, 24'hFF0000, 24'hFFF000, 24'hF00000};
   localparam logic [3:0]  WAIT_A [4] = '{4'd2, 4'd15, 4'd3, 4'd0};

   logic            clk30, reset;
   logic            cpu_as, cpu_uds, cpu_lds, cpu_write_strobe;
   logic [23:1]     cpu_addr;
   logic [15:0]     cpu_data_in;
   logic            cpu_bus_ack, cpu_bus_err;
   logic [N-1:0]    slv_cs, slv_ack;
   logic [16*N-1:0] slv_dout;
   logic [23:0]     err_addr;
   logic            err_is_timeout;
   logic [7:0]      err_count;

   logic [15:0] dout [4];
   logic        wr, chk_en;
   logic [3:0]  exp_cs;
   logic        exp_ack, exp_err;
   logic [15:0] m_data;
   logic [23:0] m_err_addr;
   logic        m_err_to;
   logic [7:0]  m_err_cnt;
   int          n_chk, n_fail, cs_hi;

   assign slv_dout = {dout[3], dout[2], dout[1], dout[0]};

   cpu_bus_fabric #(
      .NUM_REGIONS(N),
      .REGION_BASE({BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]}),
      .REGION_MASK({MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]}),
      .REGION_WAIT({WAIT_A[3], WAIT_A[2], WAIT_A[1], WAIT_A[0]}),
      .TIMEOUT    (TMO)
   ) dut (
      .clk30           (clk30),
      .reset           (reset),
      .cpu_as          (cpu_as),
      .cpu_uds         (cpu_uds),
      .cpu_lds         (cpu_lds),
      .cpu_write_strobe(cpu_write_strobe),
      .cpu_addr        (cpu_addr),
      .cpu_data_in     (cpu_data_in),
      .cpu_bus_ack     (cpu_bus_ack),
      .cpu_bus_err     (cpu_bus_err),
      .slv_cs          (slv_cs),
      .slv_dout        (slv_dout),
      .slv_ack         (slv_ack),
      .err_addr        (err_addr),
      .err_is_timeout  (err_is_timeout),
      .err_count       (err_count)
   );

   initial clk30 = 1'b0;
   always #5 clk30 = ~clk30;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk30);
      #1;
   endtask

   always @(negedge clk30)
      if (chk_en) begin
         if (slv_cs != '0) cs_hi++;
         chk("slv_cs", 32'(slv_cs), 32'(exp_cs));
         chk("bus_ack", 32'(cpu_bus_ack), 32'(exp_ack));
         chk("bus_err", 32'(cpu_bus_err), 32'(exp_err));
         chk("data_in", 32'(cpu_data_in), 32'(m_data));
         chk("err_addr", 32'(err_addr), 32'(m_err_addr));
         chk("err_to", 32'(err_is_timeout), 32'(m_err_to));
         chk("err_cnt", 32'(err_count), 32'(m_err_cnt));
      end

   // One CPU cycle: ack_dly<0 means the external slave never acks; stop_at>0 kills ACTIVE cycle stop_at
   task automatic run(input logic [23:0] addr, input int ack_dly, input int stop_at,
                      input bit stop_rst, input int hold);
      int  r, n_ack, len;
      bit  hit, acked;
      hit = 0;
      r   = 0;
      for (int i = 0; i < N; i++)
         if (!hit && (addr & MASK_A[i]) == (BASE_A[i] & MASK_A[i])) begin
            hit = 1;
            r   = i;
         end
      n_ack = !hit ? 0 : WAIT_A[r] != 4'hF ? int'(WAIT_A[r]) + 1 : ack_dly < 0 ? 1 << 20 : ack_dly + 1;
      acked = hit && n_ack <= TMO;
      len   = !hit ? 1 : acked ? n_ack : TMO;
      cpu_addr         = addr[23:1];
      cpu_write_strobe = wr;
      cpu_uds          = wr;
      cpu_lds          = !wr;
      cpu_as           = 1'b1;
      tick();
      for (int j = 1; j <= len; j++) begin
         exp_cs  = hit ? 4'(1 << r) : 4'd0;
         slv_ack = (hit && WAIT_A[r] == 4'hF && j == n_ack) ? 4'(1 << r) : 4'd0;
         if (j == stop_at) begin
            if (stop_rst) reset = 1'b1;
            else cpu_as = 1'b0;
         end
         tick();
         if (j == stop_at) begin
            reset   = 1'b0;
            slv_ack = '0;
            cpu_as  = 1'b0;
            cpu_uds = 1'b0;
            cpu_lds = 1'b0;
            exp_cs  = '0;
            if (stop_rst) begin
               m_data     = '0;
               m_err_addr = '0;
               m_err_to   = 1'b0;
               m_err_cnt  = '0;
            end
            tick();
            return;
         end
      end
      slv_ack = '0;
      exp_cs  = '0;
      if (acked) begin
         exp_ack = 1'b1;
         m_data  = dout[r];
      end else begin
         exp_err    = 1'b1;
         m_err_addr = addr;
         m_err_to   = hit;
         m_err_cnt  = m_err_cnt == 8'hFF ? 8'hFF : m_err_cnt + 8'd1;
      end
      repeat (hold) tick();
      cpu_as  = 1'b0;
      cpu_uds = 1'b0;
      cpu_lds = 1'b0;
      tick();
      exp_ack = 1'b0;
      exp_err = 1'b0;
      tick();
   endtask

   initial begin
      int base;
      n_chk = 0; n_fail = 0; cs_hi = 0; chk_en = 1'b0;
      reset = 1'b1; cpu_as = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_write_strobe = 1'b0;
      cpu_addr = '0; slv_ack = '0; wr = 1'b0;
      for (int i = 0; i < N; i++) dout[i] = '0;
      exp_cs = '0; exp_ack = 1'b0; exp_err = 1'b0;
      m_data = '0; m_err_addr = '0; m_err_to = 1'b0; m_err_cnt = '0;
      tick(); tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      dout[0] = 16'hBEEF; dout[1] = 16'h1234; dout[2] = 16'h5555; dout[3] = 16'hA5A5;
      base = cs_hi; run(24'h001000, -1, 0, 0, 2);
      chk("lit_w2_cycles", 32'(cs_hi - base), 32'd3);
      chk("lit_w2_data", 32'(cpu_data_in), 32'hBEEF);

      base = cs_hi; run(24'h300010, 5, 0, 0, 1);
      chk("lit_ext_cycles", 32'(cs_hi - base), 32'd6);
      chk("lit_ext_data", 32'(cpu_data_in), 32'h1234);

      base = cs_hi; run(24'h600000, -1, 0, 0, 1);
      chk("lit_unmap_cs", 32'(cs_hi - base), 32'd0);
      chk("lit_unmap_addr", 32'(err_addr), 32'h600000);
      chk("lit_unmap_to", 32'(err_is_timeout), 32'd0);
      chk("lit_unmap_cnt", 32'(err_count), 32'd1);

      base = cs_hi; run(24'h800002, -1, 0, 0, 0);
      chk("lit_w0_cycles", 32'(cs_hi - base), 32'd1);
      chk("lit_w0_data", 32'(cpu_data_in), 32'hA5A5);

      dout[1] = 16'hCAFE;
      base = cs_hi; run(24'h3000FE, TMO - 1, 0, 0, 1);
      chk("lit_tie_cycles", 32'(cs_hi - base), 32'd255);
      chk("lit_tie_data", 32'(cpu_data_in), 32'hCAFE);
      chk("lit_tie_cnt", 32'(err_count), 32'd1);

      dout[0] = 16'h1111;
      base = cs_hi; run(24'h001000, -1, 2, 0, 0);
      chk("lit_abort_cycles", 32'(cs_hi - base), 32'd2);
      chk("lit_abort_data", 32'(cpu_data_in), 32'hCAFE);
      chk("lit_abort_cnt", 32'(err_count), 32'd1);

      wr = 1'b1; dout[0] = 16'h2222;
      run(24'h0ABCDE, -1, 0, 0, 1);
      wr = 1'b0;
      chk("lit_write_data", 32'(cpu_data_in), 32'h2222);

      run(24'h300000, -1, 3, 1, 0);
      chk("lit_rst_cnt", 32'(err_count), 32'd0);
      chk("lit_rst_data", 32'(cpu_data_in), 32'd0);

      for (int k = 0; k < 256; k++) begin
         base = cs_hi;
         run(24'h300100, -1, 0, 0, 0);
         if (k == 0) chk("lit_tmo_cycles", 32'(cs_hi - base), 32'd255);
         if (k == 0) chk("lit_tmo_cnt1", 32'(err_count), 32'd1);
      end
      chk("lit_sat_cnt", 32'(err_count), 32'd255);
      chk("lit_tmo_flag", 32'(err_is_timeout), 32'd1);
      chk("lit_tmo_addr", 32'(err_addr), 32'h300100);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
